simon_host_if: RTL and testbench
================================

Name: simon_host_if

Overview:
- Host-side I/O stage for the SIMON datapath controller; sits directly upstream and downstream of it.
- Assembles plaintext and key words arriving over a narrow N-bit valid/ready bus into a full block and key set.
- Presents them to the controller with the newData/newKey/enc_dec request handshake.
- Captures each finished cipher block using the doneData/readData handshake and streams it back out as N-bit words.

Parameters:
- N, 16, word width in bits; block is 2N bits.
- M, 4, number of key words.
- Cw, 2, width of the internal word counter; must satisfy 2^Cw >= M.

Ports:
- clk  in  1  system clock.
- R  in  1  reset; one clock, synchronous, active-high.
- din  in  N  host input word.
- din_valid  in  1  din holds a word.
- din_sel  in  1  0 = data word, 1 = key word.
- din_enc  in  1  1 = encrypt, 0 = decrypt; sampled with data word 0.
- din_ready  out  1  word accepted when din_valid && din_ready.
- dout  out  N  output cipher word.
- dout_valid  out  1  dout holds a word.
- dout_ready  in  1  host accepts dout.
- plain  out  2N  block to controller.
- key  out  M x N  key words to controller.
- newData  out  1  data block request.
- newKey  out  1  key set request.
- enc_dec  out  1  direction for the current block.
- ldData  in  1  controller has loaded the block.
- ldKey  in  1  controller has loaded the key.
- doneData  in  1  cipher output valid at controller.
- cipher  in  2N  controller result.
- readData  out  1  cipher read acknowledge to controller.

Behaviour:
- Reset (R high at a clk edge) forces all FSMs to their first state and counters to 0. Outputs clear to 0: plain, key, newData, newKey, enc_dec, readData, dout, dout_valid. din_ready returns 1 in the following cycle.
- Data FSM D_FILL -> D_REQ -> D_BUSY -> D_FILL:
  - D_FILL: accepts data words. Word 0 goes to plain[2N-1:N] and latches din_enc into enc_dec; word 1 goes to plain[N-1:0]. After word 1 the FSM enters D_REQ.
  - D_REQ: newData = 1; plain and enc_dec are held stable. On the first cycle ldData == 1, newData drops and the FSM enters D_BUSY.
  - D_BUSY: waits for ldData == 0, then returns to D_FILL.
- Key FSM K_FILL -> K_REQ -> K_BUSY -> K_FILL has the same structure:
  - Key words fill key[0] .. key[M-1] in that order.
  - newKey is held until ldKey == 1, then the FSM waits for ldKey == 0.
  - The key register is never modified outside K_FILL.
- din_ready = (din_sel == 0) ? (data FSM in D_FILL) : (key FSM in K_FILL). It is combinational on din_sel. Words for a path that is not in its FILL state stall; they are never dropped.
- Data and key FSMs run independently; newData and newKey may be asserted in the same cycle.
- Output FSM O_IDLE -> O_ACK -> O_W0 -> O_W1 -> O_IDLE:
  - O_IDLE: when doneData == 1, capture cipher into a 2N-bit buffer and go to O_ACK.
  - O_ACK: readData = 1 until doneData == 0 is seen; then readData = 0 and go to O_W0.
  - O_W0: dout = buf[2N-1:N], dout_valid = 1; advance on dout_ready.
  - O_W1: dout = buf[N-1:0], dout_valid = 1; advance on dout_ready, then return to O_IDLE.
  - dout and dout_valid must not change while dout_valid && !dout_ready.
- Latencies:
  - Last data word accepted -> newData high on the next cycle.
  - doneData high -> readData high 1 cycle later.
  - First dout_valid no earlier than 1 cycle after doneData falls.
- readData must be 0 whenever the output FSM is not in O_ACK. The controller leaves WRITE only when doneData and readData are both low.
- Reset mid-operation:
  - Partially filled words are discarded and requests drop.
  - A pending output word is lost; dout_valid = 0 after reset.
- Counters wrap to 0 on the transition to REQ; no overflow state exists.

Test Plan:
- Reset, then send data words 0x6565, 0x6877 with din_enc = 1 -> plain = 0x65656877, enc_dec = 1; newData high until ldData pulse; din_ready for data low from D_REQ until ldData falls.
- Send key words 0x0100, 0x0908, 0x1110, 0x1918 -> key[0..3] in that order; newKey high until ldKey; key unchanged by further stalled key words.
- Drive doneData = 1 with cipher = 0xC69BE9BB, dout_ready = 1 -> readData high until doneData falls; then dout = 0xC69B followed by 0xE9BB, one word per cycle.
- Hold dout_ready = 0 for 5 cycles during O_W0 -> dout stays 0xC69B, dout_valid stays 1; a new doneData is not acknowledged until O_IDLE.
- Interleave key and data words, both requests completing in the same cycle -> newData and newKey both assert together; each drops only on its own ack.
- Assert R after one data word and during O_ACK -> all outputs 0 next cycle; a fresh two-word sequence produces the correct plain.

Source files
------------

// File: rtl/simon_host_if.sv
// Host-side word stage for the SIMON controller: packs N-bit host words into a
// 2N-bit block and M-word key, issues newData/newKey, and streams results back.
module simon_host_if #(
    parameter int N  = 16,
    parameter int M  = 4,
    parameter int Cw = 2
) (
    input  logic                clk,
    input  logic                R,
    input  logic [N-1:0]        din,
    input  logic                din_valid,
    input  logic                din_sel,
    input  logic                din_enc,
    output logic                din_ready,
    output logic [N-1:0]        dout,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic [2*N-1:0]      plain,
    output logic [M-1:0][N-1:0] key,
    output logic                newData,
    output logic                newKey,
    output logic                enc_dec,
    input  logic                ldData,
    input  logic                ldKey,
    input  logic                doneData,
    input  logic [2*N-1:0]      cipher,
    output logic                readData
);

    typedef enum logic [1:0] {D_FILL, D_REQ, D_BUSY} d_state_t;
    typedef enum logic [1:0] {K_FILL, K_REQ, K_BUSY} k_state_t;
    typedef enum logic [1:0] {O_IDLE, O_ACK, O_W0, O_W1} o_state_t;

    d_state_t       d_state_r, d_next_s;
    k_state_t       k_state_r, k_next_s;
    o_state_t       o_state_r, o_next_s;
    logic           d_cnt_r;
    logic [Cw-1:0]  k_cnt_r;
    logic           d_take_s, k_take_s;
    logic [2*N-1:0] cbuf_r;
    logic [N-1:0]   dout_next_s;

    // Words only enter while their own path is filling; others stall on the bus.
    assign din_ready = din_sel ? (k_state_r == K_FILL) : (d_state_r == D_FILL);

    // Data path next state
    always_comb begin
        d_next_s = d_state_r;
        d_take_s = 1'b0;
        case (d_state_r)
            D_FILL: begin
                if (din_valid && !din_sel) begin
                    d_take_s = 1'b1;
                    if (d_cnt_r) d_next_s = D_REQ;
                    else         d_next_s = D_FILL;
                end else begin
                    d_next_s = D_FILL;
                end
            end
            D_REQ:   if (ldData)  d_next_s = D_BUSY; else d_next_s = D_REQ;
            D_BUSY:  if (!ldData) d_next_s = D_FILL; else d_next_s = D_BUSY;
            default: d_next_s = D_FILL;
        endcase
    end

    // Data path registers: block assembly, direction latch and request flag
    always_ff @(posedge clk) begin
        if (R) begin
            d_state_r <= D_FILL;
            d_cnt_r   <= 1'b0;
            plain     <= '0;
            enc_dec   <= 1'b0;
            newData   <= 1'b0;
        end else begin
            d_state_r <= d_next_s;
            newData   <= (d_next_s == D_REQ);
            if (d_take_s) begin
                if (!d_cnt_r) begin
                    plain[2*N-1:N] <= din;
                    enc_dec        <= din_enc;
                    d_cnt_r        <= 1'b1;
                end else begin
                    plain[N-1:0]   <= din;
                    d_cnt_r        <= 1'b0;
                end
            end
        end
    end

    // Key path next state
    always_comb begin
        k_next_s = k_state_r;
        k_take_s = 1'b0;
        case (k_state_r)
            K_FILL: begin
                if (din_valid && din_sel) begin
                    k_take_s = 1'b1;
                    if (k_cnt_r == Cw'(M-1)) k_next_s = K_REQ;
                    else                     k_next_s = K_FILL;
                end else begin
                    k_next_s = K_FILL;
                end
            end
            K_REQ:   if (ldKey)  k_next_s = K_BUSY; else k_next_s = K_REQ;
            K_BUSY:  if (!ldKey) k_next_s = K_FILL; else k_next_s = K_BUSY;
            default: k_next_s = K_FILL;
        endcase
    end

    // Key path registers; key words only ever change while filling
    always_ff @(posedge clk) begin
        if (R) begin
            k_state_r <= K_FILL;
            k_cnt_r   <= '0;
            key       <= '0;
            newKey    <= 1'b0;
        end else begin
            k_state_r <= k_next_s;
            newKey    <= (k_next_s == K_REQ);
            if (k_take_s) begin
                key[k_cnt_r] <= din;
                k_cnt_r      <= (k_cnt_r == Cw'(M-1)) ? '0 : k_cnt_r + 1'b1;
            end
        end
    end

    // Output path next state and next output word (held while stalled)
    always_comb begin
        o_next_s    = o_state_r;
        dout_next_s = dout;
        case (o_state_r)
            O_IDLE:  if (doneData)   o_next_s = O_ACK;  else o_next_s = O_IDLE;
            O_ACK:   if (!doneData)  o_next_s = O_W0;   else o_next_s = O_ACK;
            O_W0:    if (dout_ready) o_next_s = O_W1;   else o_next_s = O_W0;
            O_W1:    if (dout_ready) o_next_s = O_IDLE; else o_next_s = O_W1;
            default: o_next_s = O_IDLE;
        endcase
        if (o_next_s == O_W0) begin
            dout_next_s = cbuf_r[2*N-1:N];
        end else if (o_next_s == O_W1) begin
            dout_next_s = cbuf_r[N-1:0];
        end else begin
            dout_next_s = dout;
        end
    end

    // Output path registers: result capture, acknowledge and word stream
    always_ff @(posedge clk) begin
        if (R) begin
            o_state_r  <= O_IDLE;
            cbuf_r     <= '0;
            readData   <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            o_state_r  <= o_next_s;
            readData   <= (o_next_s == O_ACK);
            dout_valid <= (o_next_s == O_W0) || (o_next_s == O_W1);
            dout       <= dout_next_s;
            if (o_state_r == O_IDLE && doneData) cbuf_r <= cipher;
        end
    end

endmodule

// File: tb/tb_simon_host_if.sv
// Directed-plus-random bench for simon_host_if; expected values come from the
// words the bench itself sent (block = {w0,w1}, key[i] = i-th key word).
module tb_simon_host_if;
    localparam int N  = 16;
    localparam int M  = 4;
    localparam int CW = 2;

    logic                clk = 1'b0;
    logic                R;
    logic [N-1:0]        din;
    logic                din_valid, din_sel, din_enc, din_ready;
    logic [N-1:0]        dout;
    logic                dout_valid, dout_ready;
    logic [2*N-1:0]      plain;
    logic [M-1:0][N-1:0] key;
    logic                newData, newKey, enc_dec;
    logic                ldData, ldKey, doneData, readData;
    logic [2*N-1:0]      cipher;

    int total = 0;
    int bad   = 0;

    simon_host_if #(.N(N), .M(M), .Cw(CW)) dut (
        .clk(clk), .R(R), .din(din), .din_valid(din_valid), .din_sel(din_sel),
        .din_enc(din_enc), .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .plain(plain), .key(key), .newData(newData),
        .newKey(newKey), .enc_dec(enc_dec), .ldData(ldData), .ldKey(ldKey),
        .doneData(doneData), .cipher(cipher), .readData(readData)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic sel, input logic [N-1:0] w, input logic enc);
        int n = 0;
        din_valid = 1'b1; din_sel = sel; din = w; din_enc = enc;
        #1;
        while (!din_ready && n < 40) begin
            tick();
            n++;
        end
        if (!din_ready) check("accept_timeout", {63'd0, din_ready}, 64'd1);
        tick();
        din_valid = 1'b0;
    endtask

    task automatic check_all_zero();
        check("rst_plain", {32'd0, plain}, 64'd0);
        check("rst_key", key, 64'd0);
        check("rst_newData", {63'd0, newData}, 64'd0);
        check("rst_newKey", {63'd0, newKey}, 64'd0);
        check("rst_enc_dec", {63'd0, enc_dec}, 64'd0);
        check("rst_readData", {63'd0, readData}, 64'd0);
        check("rst_dout", {48'd0, dout}, 64'd0);
        check("rst_dout_valid", {63'd0, dout_valid}, 64'd0);
    endtask

    // Sends a block, checks request/hold/ack behaviour.
    task automatic data_block(input logic [N-1:0] w0, input logic [N-1:0] w1, input logic enc);
        send_word(1'b0, w0, enc);
        send_word(1'b0, w1, ~enc);
        check("newData_rise", {63'd0, newData}, 64'd1);
        check("plain", {32'd0, plain}, {32'd0, w0, w1});
        check("enc_dec", {63'd0, enc_dec}, {63'd0, enc});
        din_sel = 1'b0;
        #1 check("din_ready_req", {63'd0, din_ready}, 64'd0);
        repeat (2) tick();
        check("newData_hold", {63'd0, newData}, 64'd1);
        check("plain_hold", {32'd0, plain}, {32'd0, w0, w1});
        ldData = 1'b1;
        tick();
        check("newData_drop", {63'd0, newData}, 64'd0);
        check("din_ready_busy", {63'd0, din_ready}, 64'd0);
        ldData = 1'b0;
        tick();
        check("din_ready_fill", {63'd0, din_ready}, 64'd1);
    endtask

    // Full result transfer with the host always ready.
    task automatic out_block(input logic [2*N-1:0] c);
        doneData = 1'b1; cipher = c; dout_ready = 1'b1;
        tick();
        check("readData_rise", {63'd0, readData}, 64'd1);
        cipher = ~c;
        tick();
        check("readData_hold", {63'd0, readData}, 64'd1);
        check("no_valid_in_ack", {63'd0, dout_valid}, 64'd0);
        doneData = 1'b0;
        tick();
        check("readData_fall", {63'd0, readData}, 64'd0);
        check("w0_valid", {63'd0, dout_valid}, 64'd1);
        check("w0_data", {48'd0, dout}, {48'd0, c[2*N-1:N]});
        tick();
        check("w1_valid", {63'd0, dout_valid}, 64'd1);
        check("w1_data", {48'd0, dout}, {48'd0, c[N-1:0]});
        tick();
        check("idle_valid", {63'd0, dout_valid}, 64'd0);
    endtask

    initial begin
        logic [M-1:0][N-1:0] kexp;
        logic [2*N-1:0]      c1, c2;
        logic [N-1:0]        w0, w1;

        R = 1'b1; din = '0; din_valid = 1'b0; din_sel = 1'b0; din_enc = 1'b0;
        dout_ready = 1'b0; ldData = 1'b0; ldKey = 1'b0; doneData = 1'b0; cipher = '0;
        tick(); tick();
        R = 1'b0;
        check_all_zero();
        din_sel = 1'b0; #1 check("rst_ready_data", {63'd0, din_ready}, 64'd1);
        din_sel = 1'b1; #1 check("rst_ready_key", {63'd0, din_ready}, 64'd1);
        tick();

        data_block(16'h6565, 16'h6877, 1'b1);
        repeat (3) data_block(N'($urandom), N'($urandom), 1'($urandom));

        // Key load, then a stalled key word must not disturb the key
        kexp[0] = 16'h0100; kexp[1] = 16'h0908; kexp[2] = 16'h1110; kexp[3] = 16'h1918;
        for (int i = 0; i < M; i++) send_word(1'b1, kexp[i], 1'b0);
        check("newKey_rise", {63'd0, newKey}, 64'd1);
        check("key_load", key, kexp);
        din_valid = 1'b1; din_sel = 1'b1; din = 16'hDEAD;
        repeat (3) tick();
        check("key_stall_ready", {63'd0, din_ready}, 64'd0);
        check("key_stall_hold", key, kexp);
        check("newKey_hold", {63'd0, newKey}, 64'd1);
        ldKey = 1'b1;
        tick();
        check("newKey_drop", {63'd0, newKey}, 64'd0);
        tick();
        check("key_busy_ready", {63'd0, din_ready}, 64'd0);
        check("key_busy_hold", key, kexp);
        din_valid = 1'b0; ldKey = 1'b0;
        tick();
        #1 check("key_fill_ready", {63'd0, din_ready}, 64'd1);

        out_block(32'hC69BE9BB);

        // Output backpressure and a doneData arriving while words are pending
        c1 = $urandom; c2 = $urandom;
        doneData = 1'b1; cipher = c1; dout_ready = 1'b0;
        tick();
        check("bp_readData", {63'd0, readData}, 64'd1);
        doneData = 1'b0;
        tick();
        doneData = 1'b1; cipher = c2;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_dout", {48'd0, dout}, {48'd0, c1[2*N-1:N]});
            check("bp_valid", {63'd0, dout_valid}, 64'd1);
            check("bp_no_ack", {63'd0, readData}, 64'd0);
        end
        dout_ready = 1'b1;
        tick();
        check("bp_w1", {48'd0, dout}, {48'd0, c1[N-1:0]});
        tick();
        check("bp_idle_valid", {63'd0, dout_valid}, 64'd0);
        check("bp_idle_ack", {63'd0, readData}, 64'd0);
        tick();
        check("bp_late_ack", {63'd0, readData}, 64'd1);
        cipher = ~c2; doneData = 1'b0;
        tick();
        check("bp2_w0", {48'd0, dout}, {48'd0, c2[2*N-1:N]});
        tick();
        check("bp2_w1", {48'd0, dout}, {48'd0, c2[N-1:0]});
        tick();
        check("bp2_idle", {63'd0, dout_valid}, 64'd0);

        // Interleaved data and key words; both requests up together
        w0 = $urandom; w1 = $urandom;
        for (int i = 0; i < M; i++) kexp[i] = N'($urandom);
        send_word(1'b0, w0, 1'b0);
        for (int i = 0; i < M-1; i++) send_word(1'b1, kexp[i], 1'b1);
        send_word(1'b0, w1, 1'b1);
        check("il_newData_only", {62'd0, newData, newKey}, 64'd2);
        send_word(1'b1, kexp[M-1], 1'b0);
        check("il_both", {62'd0, newData, newKey}, 64'd3);
        check("il_plain", {32'd0, plain}, {32'd0, w0, w1});
        check("il_enc", {63'd0, enc_dec}, 64'd0);
        check("il_key", key, kexp);
        ldKey = 1'b1;
        tick();
        check("il_key_ack", {62'd0, newData, newKey}, 64'd2);
        ldData = 1'b1;
        tick();
        check("il_data_ack", {62'd0, newData, newKey}, 64'd0);
        ldData = 1'b0; ldKey = 1'b0;
        tick();

        // Reset after one data word, then during the result acknowledge
        send_word(1'b0, N'($urandom), 1'b1);
        R = 1'b1;
        tick();
        R = 1'b0;
        check_all_zero();
        doneData = 1'b1; cipher = $urandom;
        tick();
        check("pre_rst_ack", {63'd0, readData}, 64'd1);
        R = 1'b1; doneData = 1'b0;
        tick();
        R = 1'b0;
        check_all_zero();
        tick();
        check("post_rst_no_word", {63'd0, dout_valid}, 64'd0);
        data_block(N'($urandom), N'($urandom), 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
